// File: rtl/ipv_expander.sv
// IPV expander: serialises an MSB-aligned thermometer vote vector onto the
// one-bit IPV line, one bit per cycle, in free-running K-cycle frames. A
// one-entry holding buffer sits between the upstream producer and the frame
// boundary, so a new vector can be accepted while the current one is sent.
module ipv_expander #(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] vov_in,
    input  logic         vov_valid,
    output logic         vov_ready,
    output logic         ipv_out,
    output logic         frame_start,
    output logic         frame_active,
    output logic         underrun,
    output logic         therm_err
);

    // Phase value of the last bit of a frame; the frame reload happens on
    // the edge that ends this phase.
    localparam logic [2:0] LAST_PHASE = 3'(K - 1);

    // Number of ones in a vector (0..K). An illegal vector is still sent as
    // its popcount, so this is the only value that travels down the line.
    function automatic logic [3:0] popcount(input logic [K-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < K; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

    // MSB-aligned thermometer code holding 'c' ones: the only legal shape of
    // an input vector (all-zero and all-one included).
    function automatic logic [K-1:0] therm_of(input logic [3:0] c);
        logic [K-1:0] t;
        t = '0;
        for (int i = 0; i < K; i++) begin
            t[K-1-i] = (4'(i) < c);
        end
        return t;
    endfunction

    // Frame phase, free-running from reset so a reducer reset on the same
    // cycle stays aligned with it.
    logic [2:0] r_phase;

    // Holding buffer: popcount of the accepted but not yet framed vector.
    logic       r_buf_full;
    logic [3:0] r_buf_cnt;

    // Frame currently on the line.
    logic [3:0] r_frame_cnt;
    logic       r_frame_active;

    // Status flags.
    logic       r_started;
    logic       r_underrun;
    logic       r_therm_err;

    logic       w_last;
    logic       w_ready;
    logic       w_xfer;
    logic [3:0] w_vec_cnt;
    logic       w_vec_legal;
    logic       w_bypass;
    logic       w_load_active;
    logic [3:0] w_load_cnt;

    // Handshake: vov_ready is high whenever the buffer is empty, or at the
    // last phase of a frame (the buffer drains into the frame on that edge,
    // so a new vector can take its place). A transfer happens on every edge
    // where vov_valid & vov_ready; vov_in is ignored while vov_valid is low.
    // vov_ready depends only on registers, never on vov_valid.
    assign w_last      = (r_phase == LAST_PHASE);
    assign w_ready     = !r_buf_full || w_last;
    assign w_xfer      = vov_valid && w_ready;
    assign w_vec_cnt   = popcount(vov_in);
    assign w_vec_legal = (vov_in == therm_of(w_vec_cnt));

    // A vector accepted at the frame boundary with an empty buffer goes
    // straight into the next frame; otherwise the buffer feeds the frame.
    assign w_bypass = w_last && !r_buf_full && w_xfer;

    // Contents of the next frame, used only on the last-phase edge.
    always_comb begin
        w_load_active = 1'b0;
        w_load_cnt    = 4'd0;
        if (r_buf_full) begin
            w_load_active = 1'b1;
            w_load_cnt    = r_buf_cnt;
        end else if (w_xfer) begin
            w_load_active = 1'b1;
            w_load_cnt    = w_vec_cnt;
        end
    end

    // Phase counter: 0..K-1, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 3'd0;
        end else if (w_last) begin
            r_phase <= 3'd0;
        end else begin
            r_phase <= r_phase + 3'd1;
        end
    end

    // Holding buffer: filled by a transfer, emptied by a frame load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_buf_cnt  <= 4'd0;
        end else if (w_xfer && !w_bypass) begin
            r_buf_full <= 1'b1;
            r_buf_cnt  <= w_vec_cnt;
        end else if (w_last) begin
            r_buf_full <= 1'b0;
        end
    end

    // Frame register: reloaded at the edge ending the last phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt    <= 4'd0;
            r_frame_active <= 1'b0;
        end else if (w_last) begin
            r_frame_cnt    <= w_load_cnt;
            r_frame_active <= w_load_active;
        end
    end

    // Status: started latch, underrun at phase 0 of idle frames once any
    // vector was accepted, and a one-cycle flag for illegal vectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_started   <= 1'b0;
            r_underrun  <= 1'b0;
            r_therm_err <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_started <= 1'b1;
            end
            // An idle next frame implies no transfer on this edge, so the
            // current started flag is the right one to look at.
            r_underrun  <= w_last && !w_load_active && r_started;
            r_therm_err <= w_xfer && !w_vec_legal;
        end
    end

    // Ones first, then zeros: phase below the frame count sends a one.
    assign ipv_out      = ({1'b0, r_phase} < r_frame_cnt);
    assign frame_start  = (r_phase == 3'd0);
    assign frame_active = r_frame_active;
    assign underrun     = r_underrun;
    assign therm_err    = r_therm_err;
    assign vov_ready    = w_ready;

endmodule

// File: tb/tb_ipv_expander.sv
// Bench for ipv_expander (K=4): table of per-scenario stimulus with
// per-cycle expected outputs, plus a scoreboard that rebuilds each active
// frame from the serial line and compares it with the vector accepted for it.
module tb_ipv_expander;

    localparam int K = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [K-1:0] vov_in;
    logic         vov_valid;
    logic         vov_ready;
    logic         ipv_out;
    logic         frame_start;
    logic         frame_active;
    logic         underrun;
    logic         therm_err;

    int checks = 0;
    int errors = 0;

    // Expected frame patterns (thermometer of the accepted popcount).
    logic [K-1:0] exp_q[$];
    bit           collecting;
    int           nbits;
    logic [K-1:0] rec;

    ipv_expander #(.K(K)) dut (
        .clk          (clk),
        .rst          (rst),
        .vov_in       (vov_in),
        .vov_valid    (vov_valid),
        .vov_ready    (vov_ready),
        .ipv_out      (ipv_out),
        .frame_start  (frame_start),
        .frame_active (frame_active),
        .underrun     (underrun),
        .therm_err    (therm_err)
    );

    // Clock.
    always #5 clk = ~clk;

    // One scenario: up to three vectors (v0 in bits 3:0), presented once at
    // 'start' or held from 'start' until all accepted; optional reset cycle;
    // expected outputs for cycles 0..15, bit c = cycle c.
    typedef struct {
        string       name;
        int          nvec;
        logic [11:0] vecs;
        int          start;
        bit          hold;
        int          rst_cyc;
        logic [15:0] e_ipv;
        logic [15:0] e_fs;
        logic [15:0] e_fa;
        logic [15:0] e_ur;
        logic [15:0] e_te;
        logic [15:0] e_rdy;
    } scen_t;

    scen_t tbl[6];

    function automatic int pop_of(input logic [K-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < K; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [K-1:0] therm(input int n);
        logic [K-1:0] t;
        t = '0;
        for (int i = 0; i < K; i++) t[K-1-i] = (i < n);
        return t;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    // Reset for one edge; returns in cycle 0.
    task automatic do_reset();
        rst       = 1'b1;
        vov_valid = 1'b0;
        vov_in    = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        collecting = 0;
    endtask

    // Scoreboard step, called at the negedge of every cycle.
    task automatic sb_cycle(input string nm, input int cyc);
        logic [K-1:0] e;
        if (vov_valid && vov_ready && !rst) exp_q.push_back(therm(pop_of(vov_in)));
        if (frame_start) begin
            collecting = frame_active;
            nbits      = 0;
            rec        = '0;
        end
        if (collecting) begin
            rec = {rec[K-2:0], ipv_out};
            nbits++;
            if (nbits == K) begin
                collecting = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s sb_frame cycle %0d: got frame %b expected no frame", nm, cyc, rec);
                end else begin
                    e = exp_q.pop_front();
                    if (rec !== e) begin
                        errors++;
                        $display("FAIL %s sb_frame cycle %0d: got %b expected %b", nm, cyc, rec, e);
                    end
                end
            end
        end
    endtask

    task automatic sb_drained(input string nm);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s sb_drain: got %0d pending expected 0", nm, exp_q.size());
        end
    endtask

    task automatic run_scen(input scen_t s);
        int sent;
        sent = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            rst = (c == s.rst_cyc);
            if (sent < s.nvec && (s.hold ? (c >= s.start) : (c == s.start))) begin
                vov_valid = 1'b1;
                vov_in    = s.vecs[4*sent +: 4];
            end else begin
                vov_valid = 1'b0;
                vov_in    = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            chk({s.name, " ipv_out"},      c, ipv_out,      s.e_ipv[c]);
            chk({s.name, " frame_start"},  c, frame_start,  s.e_fs[c]);
            chk({s.name, " frame_active"}, c, frame_active, s.e_fa[c]);
            chk({s.name, " underrun"},     c, underrun,     s.e_ur[c]);
            chk({s.name, " therm_err"},    c, therm_err,    s.e_te[c]);
            chk({s.name, " vov_ready"},    c, vov_ready,    s.e_rdy[c]);
            if (vov_valid && vov_ready) sent++;
            sb_cycle(s.name, c);
            @(posedge clk);
            #1;
            if (rst) begin
                exp_q.delete();
                collecting = 0;
            end
        end
        rst       = 1'b0;
        vov_valid = 1'b0;
        sb_drained(s.name);
    endtask

    // Random traffic: scoreboard on frames, bench-side legality on therm_err.
    task automatic run_random();
        bit te_exp;
        te_exp = 0;
        do_reset();
        for (int c = 0; c < 64; c++) begin
            vov_valid = (c < 48) ? 1'($urandom_range(0, 1)) : 1'b0;
            if ($urandom_range(0, 4) == 0) vov_in = 4'($urandom_range(0, 15));
            else                           vov_in = therm($urandom_range(0, K));
            @(negedge clk);
            chk("random therm_err", c, therm_err, te_exp);
            te_exp = vov_valid && vov_ready && (vov_in != therm(pop_of(vov_in)));
            sb_cycle("random", c);
            @(posedge clk);
            #1;
        end
        sb_drained("random");
    endtask

    initial begin
        rst       = 1'b1;
        vov_valid = 1'b0;
        vov_in    = '0;
        collecting = 0;
        nbits     = 0;
        rec       = '0;

        tbl[0] = '{"reset_idle", 0, 12'h000, 0, 0, -1,
                   16'h0000, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        tbl[1] = '{"single", 1, 12'h00C, 0, 0, -1,
                   16'h0030, 16'h1111, 16'h00F0, 16'h1100, 16'h0000, 16'hFFF9};
        tbl[2] = '{"back_to_back", 3, 12'hF0E, 0, 1, -1,
                   16'hF070, 16'h1111, 16'hFFF0, 16'h0000, 16'h0000, 16'hF889};
        tbl[3] = '{"boundary", 1, 12'h008, 3, 0, -1,
                   16'h0010, 16'h1111, 16'h00F0, 16'h1100, 16'h0000, 16'hFFFF};
        tbl[4] = '{"illegal", 1, 12'h00A, 1, 0, -1,
                   16'h0030, 16'h1111, 16'h00F0, 16'h1100, 16'h0004, 16'hFFFB};
        tbl[5] = '{"reset_mid", 1, 12'h00F, 0, 0, 5,
                   16'h0030, 16'h4451, 16'h0030, 16'h0000, 16'h0000, 16'hFFF9};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) run_scen(tbl[i]);
        run_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipv_expander.md
Name: ipv_expander

Overview:
- Transmit-side counterpart of the IPV reducer: takes a k-bit vote vector (MSB-aligned thermometer code) and serialises it onto the one-bit IPV line, one bit per cycle, in fixed k-cycle frames.
- Frame phase runs freely from reset, so a reducer reset on the same cycle stays frame-aligned with it.
- A one-entry holding buffer decouples the upstream valid/ready producer from the frame boundary.

Parameters:
- K, 4, frame length in bits and vector width; legal range 2..8.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- vov_in  input  K  vector to send. Bit K-1 is the MSB.
- vov_valid  input  1  vov_in is valid.
- vov_ready  output  1  block can accept vov_in this cycle.
- ipv_out  output  1  serial IPV bit for the current frame phase.
- frame_start  output  1  high during phase 0 of every frame.
- frame_active  output  1  current frame carries accepted data; low for idle frames.
- underrun  output  1  one-cycle pulse at phase 0 of an idle frame after first acceptance since reset.
- therm_err  output  1  one-cycle pulse the cycle after a non-thermometer vector is accepted.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - phase=0; buffer empty; frame count register=0.
  - started=0; frame_active=0; underrun=0; therm_err=0.
  - ipv_out=0; vov_ready=1.
  - Reset mid-frame discards both the buffered vector and the in-flight vector.
- Phase counter:
  - 3-bit, counts 0..K-1 and wraps to 0.
  - First cycle after reset release is phase 0.
  - frame_start = (phase==0), combinational from the phase register.
- Handshake:
  - vov_ready = buffer empty OR phase==K-1.
  - A transfer occurs on any edge where vov_valid & vov_ready.
  - The transfer writes popcount(vov_in) (4-bit, range 0..K) into the buffer, marks it full, and sets started=1.
  - vov_in is don't-care when vov_valid=0.
- Frame load, at the edge ending phase K-1:
  - Buffer full: frame count register <= buffer count; frame_active <= 1; buffer marked empty.
  - Buffer empty: frame count register <= 0; frame_active <= 0.
  - Transfer on the same edge: the old buffer contents load into the frame and the new vector occupies the buffer. No loss and no gap.
- Serial output, combinational from registers: ipv_out = (phase < frame count register).
  - Result: popcount ones first, then zeros.
  - A reducer fed this stream reconstructs the thermometer code {count ones, zeros}.
- Thermometer check:
  - Legal vectors are of the form 1...10...0, including all-zero and all-one.
  - Accepting an illegal vector pulses therm_err on the next cycle.
  - An illegal vector is still sent as its popcount.
- Underrun: registered; high during phase 0 of a frame when frame_active=0 and started=1.
- Latency: a vector accepted while the buffer is empty is emitted in the next frame whose phase-0 cycle follows the accepting edge.
  - Minimum latency is 1 cycle (accept at phase K-1).
  - Maximum latency is K cycles (accept at phase 0).
- Steady-state throughput: one vector per K cycles. A source holding vov_valid=1 is back-pressured; vov_ready pulses only at phase K-1 once the buffer is full.
- Out-of-range K (outside 2..8) is not supported.

Test Plan (K=4, cycle 0 = first cycle after rst release):
- Reset idle:
  - Stimulus: no valid for 12 cycles.
  - Required: ipv_out=0 throughout; frame_start high on cycles 0, 4, 8; frame_active=0; underrun=0 (started=0); vov_ready=1.
- Single vector:
  - Stimulus: vov_in=4'b1100 with valid on cycle 0.
  - Required: accepted cycle 0. Cycles 4-7: ipv_out=1,1,0,0 and frame_active=1. Cycle 8: underrun=1, frame_active=0.
- Back-to-back:
  - Stimulus: valid held with 4'b1110, then 4'b0000, then 4'b1111 from cycle 0.
  - Required: transfers on cycles 0, 3, 7.
  - Required frames: cycles 4-7 give 1,1,1,0; cycles 8-11 give 0,0,0,0 with frame_active=1; cycles 12-15 give 1,1,1,1.
  - Required: vov_ready=0 on cycles 1, 2, 4, 5, 6; no underrun through cycle 15.
- Boundary accept:
  - Stimulus: buffer empty, vov_in=4'b1000 presented on cycle 3 only.
  - Required: accepted cycle 3; cycles 4-7 give 1,0,0,0.
- Illegal vector:
  - Stimulus: vov_in=4'b1010 accepted on cycle 1.
  - Required: therm_err=1 on cycle 2 only; cycles 4-7 give 1,1,0,0.
- Reset mid-frame:
  - Stimulus: 4'b1111 accepted on cycle 0; rst=1 on cycle 5; released at cycle 6.
  - Required: ipv_out=0 and frame_start=1 in the first post-reset cycle; rest of the 1111 frame not emitted; no underrun.
  - Required: round-trip through the reducer yields vov=0.
